// File: rtl/rv32i_rename_unit_if.sv
// Decode/rename/commit bundle for the rv32i rename stage.
//
// Ports grouped here:
//   decode side  : decode_vld, rs1_vld, rs2_vld, rd_vld,
//                  src1_arch_rf_idx, src2_arch_rf_idx, dst_arch_rf_idx, rdy
//   dispatch side: rename_vld, src1_phys_idx, src2_phys_idx,
//                  dst_phys_idx, old_dst_phys_idx
//   retire side  : commit_vld, commit_arch_idx, commit_phys_idx,
//                  commit_old_phys_idx, flush
// Slot j of every packed field sits at [j*WIDTH +: WIDTH].
// The master modport drives decode/commit/flush and observes the rename
// results; the slave modport is the rename unit itself.
interface rv32i_rename_unit_if #(
    parameter int DEC_WIDTH = 2,
    parameter int ARCH_REGS = 32,
    parameter int PHYS_REGS = 64
);
    localparam int AIDX_BW = $clog2(ARCH_REGS);
    localparam int PIDX_BW = $clog2(PHYS_REGS);

    logic [DEC_WIDTH-1:0]         decode_vld;
    logic [DEC_WIDTH-1:0]         rs1_vld;
    logic [DEC_WIDTH-1:0]         rs2_vld;
    logic [DEC_WIDTH-1:0]         rd_vld;
    logic [DEC_WIDTH*AIDX_BW-1:0] src1_arch_rf_idx;
    logic [DEC_WIDTH*AIDX_BW-1:0] src2_arch_rf_idx;
    logic [DEC_WIDTH*AIDX_BW-1:0] dst_arch_rf_idx;
    logic                         rdy;

    logic [DEC_WIDTH-1:0]         rename_vld;
    logic [DEC_WIDTH*PIDX_BW-1:0] src1_phys_idx;
    logic [DEC_WIDTH*PIDX_BW-1:0] src2_phys_idx;
    logic [DEC_WIDTH*PIDX_BW-1:0] dst_phys_idx;
    logic [DEC_WIDTH*PIDX_BW-1:0] old_dst_phys_idx;

    logic [DEC_WIDTH-1:0]         commit_vld;
    logic [DEC_WIDTH*AIDX_BW-1:0] commit_arch_idx;
    logic [DEC_WIDTH*PIDX_BW-1:0] commit_phys_idx;
    logic [DEC_WIDTH*PIDX_BW-1:0] commit_old_phys_idx;
    logic                         flush;

    modport master (
        output decode_vld, rs1_vld, rs2_vld, rd_vld,
        output src1_arch_rf_idx, src2_arch_rf_idx, dst_arch_rf_idx,
        input  rdy,
        input  rename_vld, src1_phys_idx, src2_phys_idx, dst_phys_idx, old_dst_phys_idx,
        output commit_vld, commit_arch_idx, commit_phys_idx, commit_old_phys_idx,
        output flush
    );

    modport slave (
        input  decode_vld, rs1_vld, rs2_vld, rd_vld,
        input  src1_arch_rf_idx, src2_arch_rf_idx, dst_arch_rf_idx,
        output rdy,
        output rename_vld, src1_phys_idx, src2_phys_idx, dst_phys_idx, old_dst_phys_idx,
        input  commit_vld, commit_arch_idx, commit_phys_idx, commit_old_phys_idx,
        input  flush
    );
endinterface

// File: rtl/rv32i_rename_unit.sv
// Multi-wide register rename stage for the rv32i out-of-order core.
//
// Each cycle up to DEC_WIDTH decoded instructions are mapped from
// architectural to physical registers through a speculative map table;
// destinations take the lowest-numbered free physical registers.
// Retirement updates a retirement map and returns old registers to the
// free vector; a flush rebuilds the speculative map and free vector from
// the retirement map.
//
// Ports:
//   clk - rising-edge clock
//   rst - synchronous active-high reset
//   bus - rv32i_rename_unit_if.slave (decode inputs, rdy, registered
//         rename results, commit inputs, flush)
module rv32i_rename_unit #(
    parameter int DEC_WIDTH = 2,
    parameter int ARCH_REGS = 32,
    parameter int PHYS_REGS = 64
) (
    input  logic               clk,
    input  logic               rst,
    rv32i_rename_unit_if.slave bus
);
    localparam int AIDX_BW = $clog2(ARCH_REGS);
    localparam int PIDX_BW = $clog2(PHYS_REGS);
    localparam logic [PIDX_BW:0] GROUP_NEED = (PIDX_BW+1)'(DEC_WIDTH);

    logic [PIDX_BW-1:0]           spec_map [ARCH_REGS];
    logic [PIDX_BW-1:0]           ret_map  [ARCH_REGS];
    logic [PHYS_REGS-1:0]         free;

    logic [PIDX_BW:0]             free_count;
    logic                         rdy;
    logic                         accept;

    logic [PIDX_BW-1:0]           work_map [ARCH_REGS];
    logic [PHYS_REGS-1:0]         alloc_mask;
    logic [DEC_WIDTH-1:0]         ren;
    logic [DEC_WIDTH*PIDX_BW-1:0] src1_next;
    logic [DEC_WIDTH*PIDX_BW-1:0] src2_next;
    logic [DEC_WIDTH*PIDX_BW-1:0] dst_next;
    logic [DEC_WIDTH*PIDX_BW-1:0] old_next;

    logic [PIDX_BW-1:0]           ret_next [ARCH_REGS];
    logic [PHYS_REGS-1:0]         release_mask;
    logic [PHYS_REGS-1:0]         in_ret;

    // Number of free physical registers. The readiness test is deliberately
    // conservative: a full group's worth must be free regardless of how many
    // slots actually write a destination.
    always_comb begin
        free_count = '0;
        for (int p = 0; p < PHYS_REGS; p++) begin
            free_count = free_count + {{PIDX_BW{1'b0}}, free[p]};
        end
    end

    assign rdy     = !rst && !bus.flush && (free_count >= GROUP_NEED);
    assign bus.rdy = rdy;
    assign accept  = (|bus.decode_vld) && rdy;

    // Rename the group slot by slot against a working copy of the map.
    // Updating the copy as each slot allocates gives the intra-group bypass
    // for free: later slots see the newest earlier writer, and the final copy
    // is the post-group speculative map (last writer wins).
    always_comb begin
        logic [PHYS_REGS-1:0] avail;
        logic                 found;
        logic [PIDX_BW-1:0]   pick;
        logic [AIDX_BW-1:0]   a1;
        logic [AIDX_BW-1:0]   a2;
        logic [AIDX_BW-1:0]   ad;

        for (int a = 0; a < ARCH_REGS; a++) begin
            work_map[a] = spec_map[a];
        end
        avail      = free;
        alloc_mask = '0;
        ren        = '0;
        src1_next  = '0;
        src2_next  = '0;
        dst_next   = '0;
        old_next   = '0;
        found      = 1'b0;
        pick       = '0;
        a1         = '0;
        a2         = '0;
        ad         = '0;

        for (int j = 0; j < DEC_WIDTH; j++) begin
            a1     = bus.src1_arch_rf_idx[j*AIDX_BW +: AIDX_BW];
            a2     = bus.src2_arch_rf_idx[j*AIDX_BW +: AIDX_BW];
            ad     = bus.dst_arch_rf_idx[j*AIDX_BW +: AIDX_BW];
            ren[j] = bus.decode_vld[j] && bus.rd_vld[j] && (ad != '0);

            // Lowest free register not already taken by an earlier slot.
            found = 1'b0;
            pick  = '0;
            for (int p = 0; p < PHYS_REGS; p++) begin
                if (!found && avail[p]) begin
                    found = 1'b1;
                    pick  = PIDX_BW'(p);
                end
            end

            // x0 and unused operands read as p0.
            if (bus.decode_vld[j]) begin
                if (bus.rs1_vld[j] && (a1 != '0)) begin
                    src1_next[j*PIDX_BW +: PIDX_BW] = work_map[a1];
                end
                if (bus.rs2_vld[j] && (a2 != '0)) begin
                    src2_next[j*PIDX_BW +: PIDX_BW] = work_map[a2];
                end
            end

            if (ren[j] && found) begin
                dst_next[j*PIDX_BW +: PIDX_BW] = pick;
                old_next[j*PIDX_BW +: PIDX_BW] = work_map[ad];
                work_map[ad]     = pick;
                avail[pick]      = 1'b0;
                alloc_mask[pick] = 1'b1;
            end
        end
    end

    // Retirement view including this cycle's commits. A flush in the same
    // cycle must see these, so the free vector after a flush is derived from
    // which physical registers the updated retirement map still references.
    always_comb begin
        logic [AIDX_BW-1:0] ca;
        logic [PIDX_BW-1:0] cp;
        logic [PIDX_BW-1:0] co;

        for (int a = 0; a < ARCH_REGS; a++) begin
            ret_next[a] = ret_map[a];
        end
        release_mask = '0;
        in_ret       = '0;
        ca           = '0;
        cp           = '0;
        co           = '0;

        for (int j = 0; j < DEC_WIDTH; j++) begin
            ca = bus.commit_arch_idx[j*AIDX_BW +: AIDX_BW];
            cp = bus.commit_phys_idx[j*PIDX_BW +: PIDX_BW];
            co = bus.commit_old_phys_idx[j*PIDX_BW +: PIDX_BW];
            if (bus.commit_vld[j]) begin
                ret_next[ca] = cp;
                if (co != '0) begin
                    release_mask[co] = 1'b1;
                end
            end
        end

        for (int a = 0; a < ARCH_REGS; a++) begin
            in_ret[ret_next[a]] = 1'b1;
        end
    end

    // State and registered outputs. Commit always updates the retirement
    // map; flush overrides any rename activity. Registers released by a
    // commit only join the free vector at this edge, so they are never
    // allocatable in the cycle they are released.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int a = 0; a < ARCH_REGS; a++) begin
                spec_map[a] <= PIDX_BW'(a);
                ret_map[a]  <= PIDX_BW'(a);
            end
            for (int p = 0; p < PHYS_REGS; p++) begin
                free[p] <= (p >= ARCH_REGS);
            end
            bus.rename_vld       <= '0;
            bus.src1_phys_idx    <= '0;
            bus.src2_phys_idx    <= '0;
            bus.dst_phys_idx     <= '0;
            bus.old_dst_phys_idx <= '0;
        end else begin
            for (int a = 0; a < ARCH_REGS; a++) begin
                ret_map[a] <= ret_next[a];
            end

            if (bus.flush) begin
                for (int a = 0; a < ARCH_REGS; a++) begin
                    spec_map[a] <= ret_next[a];
                end
                free                 <= ~in_ret;
                bus.rename_vld       <= '0;
                bus.src1_phys_idx    <= '0;
                bus.src2_phys_idx    <= '0;
                bus.dst_phys_idx     <= '0;
                bus.old_dst_phys_idx <= '0;
            end else if (accept) begin
                for (int a = 0; a < ARCH_REGS; a++) begin
                    spec_map[a] <= work_map[a];
                end
                free                 <= (free & ~alloc_mask) | release_mask;
                bus.rename_vld       <= bus.decode_vld;
                bus.src1_phys_idx    <= src1_next;
                bus.src2_phys_idx    <= src2_next;
                bus.dst_phys_idx     <= dst_next;
                bus.old_dst_phys_idx <= old_next;
            end else begin
                free                 <= free | release_mask;
                bus.rename_vld       <= '0;
                bus.src1_phys_idx    <= '0;
                bus.src2_phys_idx    <= '0;
                bus.dst_phys_idx     <= '0;
                bus.old_dst_phys_idx <= '0;
            end
        end
    end
endmodule
